fill_gen: RTL
=============

FILL_GEN -- requirements
Module: fill_gen

Interface
REQ-001 Parameter DW, default 64: destination data width in bits; SHALL be a multiple of 8, range 8..256.
REQ-002 Parameter LW, default 24: width of the beat-count field.
REQ-003 wb_clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-004 wb_rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in S_IDLE; the command is accepted on a cycle where cmd_valid and cmd_ready are both high.
REQ-007 cmd_len  in  LW  number of DW-bit beats to write; captured on accept.
REQ-008 cmd_pat  in  8  seed byte; captured on accept.
REQ-009 cmd_mode  in  2  pattern mode: 0 constant, 1 incrementing byte, 2 walking beat counter, 3 reserved (treated as 0); captured on accept.
REQ-010 abort  in  1  synchronous cancel of the active command.
REQ-011 m_dst_putn  out  1  active-low write strobe to the destination FIFO.
REQ-012 m_dst  out  DW  write data.
REQ-013 m_dst_last  out  1  marks the final beat; valid only when m_dst_putn is low.
REQ-014 m_dst_full  in  1  destination FIFO full.
REQ-015 m_endn  out  1  active-low, one-cycle command-complete pulse.
REQ-016 No output SHALL be tri-stated; all outputs are always driven.

Function
REQ-017 States: S_IDLE, S_RUN, S_WAIT, S_END.
REQ-018 S_IDLE -> S_RUN on accept when cmd_len != 0.
REQ-019 S_IDLE -> S_END on accept when cmd_len == 0; no beat is written.
REQ-020 S_RUN -> S_WAIT when m_dst_full = 1 and abort = 0.
REQ-021 S_WAIT -> S_RUN when m_dst_full = 0 and abort = 0.
REQ-022 S_RUN -> S_END in the cycle the last beat is written.
REQ-023 S_RUN or S_WAIT -> S_END when abort = 1; abort takes priority over all other events.
REQ-024 S_END -> S_IDLE unconditionally after one cycle.
REQ-025 m_dst_putn = !(state == S_RUN && !m_dst_full && !abort), combinational; the first beat can be written in the cycle after accept.
REQ-026 The remaining-beat counter (LW bits) SHALL load cmd_len on accept and decrement on each written beat.
REQ-027 m_dst_last = 1 exactly when a beat is written with remaining == 1.
REQ-028 Abort SHALL never produce m_dst_last.
REQ-029 Mode 0: every byte lane of m_dst = pat.
REQ-030 Mode 1: byte lane k of beat b = (pat + b*(DW/8) + k) mod 256.
REQ-031 Mode 2: beat b = {DW/8-1 bytes of pat, low byte = (pat + b) mod 256}, placed in the MS lanes down to lane 1.
REQ-032 The beat index b SHALL start at 0 and advance only on a written beat.
REQ-033 m_dst SHALL remain stable while in S_WAIT.
REQ-034 All pattern arithmetic is 8-bit and wraps modulo 256 with no carry between lanes.
REQ-035 m_endn = 0 exactly in the S_END cycle; this applies to normal completion, zero-length commands and abort.
REQ-036 cmd_valid outside S_IDLE SHALL be ignored, with no queueing.
REQ-037 A cmd_len of all-ones SHALL run 2^LW-1 beats without counter overflow.

Reset
REQ-038 While wb_rst_ni = 0: state = S_IDLE, counter = 0, beat index = 0, captured pat/mode = 0.
REQ-039 While wb_rst_ni = 0 the outputs SHALL be: cmd_ready = 1, m_dst_putn = 1, m_dst_last = 0, m_endn = 1, m_dst = 0.
REQ-040 Reset asserted mid-command SHALL discard the command without an m_endn pulse.
REQ-041 The first accept SHALL be possible on the first clock edge after deassertion.

Structure
REQ-042 Shared package fill_pkg SHALL hold the state encoding (2-bit) and the mode constants FILL_CONST, FILL_INC, FILL_WALK.
REQ-043 Sub-module fill_pat_gen (combinational; inputs pat, mode, beat index; output DW bits) SHALL compute REQ-029..REQ-031.
REQ-044 The FSM, counter and handshake SHALL reside in fill_gen.

Verification
REQ-045 Constant mode: DW=64, len=4, pat=0xA5, full=0 -> 4 consecutive putn-low cycles, m_dst=0xA5A5A5A5A5A5A5A5, last on beat 4, endn low the next cycle.
REQ-046 Incrementing mode: len=2, pat=0xFE -> beat0 = 0x050403020100FFFE, beat1 = 0x0D0C0B0A09080706 (lane0 in LSB).
REQ-047 Backpressure: len=3, full high on cycles 2-4 after accept -> puts only when full=0, state S_WAIT, data held, exactly 3 puts, last only on the third.
REQ-048 Zero length: len=0 -> no putn low; endn low in the cycle after accept; cmd_ready high again the cycle after that.
REQ-049 Abort: len=10, abort after beat 5 -> exactly 5 puts, no last, one endn pulse, then IDLE.
REQ-050 Reset mid-command: wb_rst_ni low during beat 3 of len=8 -> putn=1 immediately (asynchronous), no endn, a new command is accepted after release.

Source files
------------

// File: rtl/fill_pkg.sv
// ============================================================================
// Module      : fill_pkg
// Description : Shared state encoding and pattern-mode constants for fill_gen.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package fill_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WAIT = 2'd2,
        S_END  = 2'd3
    } fill_state_t;

    localparam logic [1:0] FILL_CONST = 2'd0;
    localparam logic [1:0] FILL_INC   = 2'd1;
    localparam logic [1:0] FILL_WALK  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fill_pat_gen.sv
// ============================================================================
// Module      : fill_pat_gen
// Description : Combinational per-lane fill pattern for one destination beat.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fill_pat_gen
    import fill_pkg::*;
#(
    parameter int DW = 64
) (
    input  logic [7:0]    i_pat,
    input  logic [1:0]    i_mode,
    input  logic [7:0]    i_beat,
    output logic [DW-1:0] o_data
);

    localparam int         NB   = DW / 8;
    localparam logic [7:0] c_nb = 8'(NB);

    // Only b mod 256 matters, since every lane wraps independently in 8 bits.
    logic [7:0] w_inc_base;
    assign w_inc_base = i_pat + (i_beat * c_nb);

    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [7:0] w_lane;
        always_comb begin
            w_lane = i_pat;
            case (i_mode)
                FILL_INC:  w_lane = w_inc_base + 8'(k);
                FILL_WALK: w_lane = (k == 0) ? (i_pat + i_beat) : i_pat;
                default:   w_lane = i_pat;
            endcase
        end
        assign o_data[8*k +: 8] = w_lane;
    end

endmodule

`default_nettype wire

// File: rtl/fill_gen.sv
// ============================================================================
// Module      : fill_gen
// Description : Command-driven fill engine writing patterned beats to a FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module fill_gen
    import fill_pkg::*;
#(
    parameter int DW = 64,
    parameter int LW = 24
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [LW-1:0] cmd_len,
    input  logic [7:0]    cmd_pat,
    input  logic [1:0]    cmd_mode,
    input  logic          abort,
    output logic          m_dst_putn,
    output logic [DW-1:0] m_dst,
    output logic          m_dst_last,
    input  logic          m_dst_full,
    output logic          m_endn
);

    fill_state_t   r_state;
    fill_state_t   w_next;
    logic [LW-1:0] r_remaining;
    logic [7:0]    r_beat;
    logic [7:0]    r_pat;
    logic [1:0]    r_mode;
    logic          w_accept;
    logic          w_put;

    assign cmd_ready  = (r_state == S_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_put      = (r_state == S_RUN) && !m_dst_full && !abort;
    assign m_dst_putn = !w_put;
    assign m_dst_last = w_put && (r_remaining == LW'(1));
    assign m_endn     = (r_state != S_END);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (cmd_len == '0) ? S_END : S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_next = S_END;
                end else if (m_dst_full) begin
                    w_next = S_WAIT;
                end else if (r_remaining == LW'(1)) begin
                    w_next = S_END;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    w_next = S_END;
                end else if (!m_dst_full) begin
                    w_next = S_RUN;
                end
            end
            S_END:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_beat      <= '0;
            r_pat       <= '0;
            r_mode      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_remaining <= cmd_len;
                r_beat      <= '0;
                r_pat       <= cmd_pat;
                r_mode      <= cmd_mode;
            end else if (w_put) begin
                r_remaining <= r_remaining - LW'(1);
                r_beat      <= r_beat + 8'd1;
            end
        end
    end

    fill_pat_gen #(
        .DW (DW)
    ) u_pat_gen (
        .i_pat  (r_pat),
        .i_mode (r_mode),
        .i_beat (r_beat),
        .o_data (m_dst)
    );

endmodule

`default_nettype wire
